fpu_mul_operand_queue_sp: RTL and testbench
===========================================

# fpu_mul_operand_queue_sp

Upstream operand-staging stage for the single-precision multiplier `fpu_multiplier_sp`. It buffers IEEE-754 binary32 operand pairs in a small FIFO with valid/ready handshakes. On enqueue it classifies each operand. For pairs whose product is decided by special-case rules (NaN, Inf, zero), it precomputes the result so downstream logic can bypass the multiplier.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `STALL_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous queue clear.
- `in_valid`  in  1: operand pair offered.
- `in_ready`  out  1: queue can accept a pair.
- `in_a`, `in_b`  in  32 each: binary32 operands.
- `out_valid`  out  1: head entry present.
- `out_ready`  in  1: consumer takes the head entry.
- `out_a`, `out_b`  out  32 each: head operands, after the optional DAZ flush.
- `out_special`  out  1: the head product is decided without multiplication.
- `out_special_result`  out  32: precomputed product when `out_special`=1; 0 otherwise.
- `count`  out  $clog2(DEPTH)+1: occupancy.
- `stall_cnt`  out  STALL_W: saturating count of refused offers.

## Operation
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. `out_valid = (count != 0)`.
- Storage is a circular buffer. Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Each entry stores: a, b, special flag, special result.
- Outputs read the head entry combinationally from storage registers (first-word fall-through).
- Classification is applied per operand on push:
  - ZERO: exp=0, frac=0.
  - SUB: exp=0, frac≠0.
  - NORM.
  - INF: exp=0xFF, frac=0.
  - NAN: exp=0xFF, frac≠0.
- Special-case rules, with s = a[31]^b[31], in priority order:
  - Either operand NAN → 0x7FC00000.
  - INF × ZERO (either order) → 0x7FC00000.
  - Either operand INF → {s, 0xFF, 23'b0}.
  - Either operand ZERO → {s, 31'b0}.
  - Otherwise `out_special`=0 and the result field is 0.
- `stall_cnt` increments each cycle `in_valid && !in_ready`. It saturates at all-ones and is cleared only by reset.
- `flush` resets pointers and `count` to 0. It takes precedence over any push or pop in the same cycle; offered data is dropped.
- Boundaries:
  - Full, with pop and push offered in the same cycle: push refused, pop proceeds.
  - Empty: a pop is impossible (`out_valid`=0).
  - Push and pop at 0<count<DEPTH: `count` unchanged and FIFO order preserved.

## Timing
- Enqueue-to-output latency is 1 cycle. A pair pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N when the queue was empty.
- `in_ready` and `out_valid` depend only on registered `count`. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- Reset (async assert, sync-safe release) values:
  - Pointers, `count`, `stall_cnt` = 0.
  - `out_valid`=0, `in_ready`=1.
  - All storage = 0, so `out_a`/`out_b`/`out_special_result` = 0 and `out_special`=0.
- Reset mid-operation discards all entries immediately.

## Configuration
- `FPU_DAZ_EN` defined: a SUB operand is replaced on push by a signed zero of the same sign and then classified as ZERO. It is stored flushed, so `out_a`/`out_b` show the flushed value.
- `FPU_DAZ_EN` undefined: operands are stored unmodified, and SUB is treated as NORM for the special-case rules.

## Structure
- Package `fpu_sp_pkg` holds:
  - `fp_class_e` enum (ZERO, SUB, NORM, INF, NAN).
  - Constants `FP_QNAN_SP`=0x7FC00000, `FP_EXP_MAX_SP`=0xFF.
  - A function `fp_classify_sp`.
- One sub-module, `fpu_special_case_sp`: combinational; takes a, b and returns special and result. It is reused later beside the multiplier.

## Test plan
- Reset: drive `rst_n`=0 mid-stream, then release → `count`=0, `out_valid`=0, `in_ready`=1, `out_a`=0.
- Normal pair: push 0x40000000 and 0x40400000 → next cycle `out_valid`=1, operands unchanged, `out_special`=0, result 0.
- Specials:
  - 0x7F800000 × 0x00000000 → `out_special`=1, result 0x7FC00000.
  - 0xFF800000 × 0x40000000 → result 0xFF800000.
  - 0x80000000 × 0x3F800000 → result 0x80000000.
- Full: `out_ready`=0 with 5 consecutive offers → `count`=4, `in_ready`=0, `stall_cnt`=1 after the 5th cycle. Then `out_ready`=1 → entries emerge in push order, one per cycle.
- Concurrent push/pop at `count`=2 for 8 cycles → `count` stays 2, order intact. Then `flush` with push and pop both asserted → `count`=0 next cycle.
- DAZ:
  - With `FPU_DAZ_EN`: push 0x80000001 × 0x3F800000 → `out_a`=0x80000000, `out_special`=1, result 0x80000000.
  - Without `FPU_DAZ_EN`: `out_a`=0x80000001, `out_special`=0.

Source files
------------

// File: rtl/fpu_sp_pkg.sv
// -----------------------------------------------------------------------------
// fpu_sp_pkg
// Shared single-precision (IEEE-754 binary32) definitions for the FPU
// multiplier path: operand class enum, special-value constants, the operand
// classifier, a denormals-are-zero helper and the operand-queue entry layout.
// -----------------------------------------------------------------------------
package fpu_sp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_e;

    localparam logic [31:0] FP_QNAN_SP    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX_SP = 8'hFF;

    // One queued operand pair plus its precomputed special-case outcome.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        special;
        logic [31:0] result;
    } q_entry_t;

    function automatic fp_class_e fp_classify_sp(input logic [31:0] x);
        logic [7:0]  exp_f;
        logic [22:0] frac_f;
        exp_f  = x[30:23];
        frac_f = x[22:0];
        if (exp_f == 8'h00) begin
            return (frac_f == '0) ? ZERO : SUB;
        end else if (exp_f == FP_EXP_MAX_SP) begin
            return (frac_f == '0) ? INF : NAN;
        end
        return NORM;
    endfunction

    // Subnormal -> signed zero of the same sign; every other value passes through.
    function automatic logic [31:0] fp_daz_sp(input logic [31:0] x);
        return (fp_classify_sp(x) == SUB) ? {x[31], 31'b0} : x;
    endfunction

endpackage

// File: rtl/fpu_special_case_sp.sv
// -----------------------------------------------------------------------------
// fpu_special_case_sp
// Combinational special-case resolver for a binary32 product a*b. Flags pairs
// whose product is fixed by NaN / Inf / zero rules and supplies that product.
// SUB operands fall through to the multiplier (treated like NORM).
//
// Ports:
//   a_i, b_i   in  32  operands
//   special_o  out 1   product decided without multiplication
//   result_o   out 32  precomputed product when special_o=1, else 0
// -----------------------------------------------------------------------------
module fpu_special_case_sp
    import fpu_sp_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        special_o,
    output logic [31:0] result_o
);

    fp_class_e cls_a;
    fp_class_e cls_b;
    logic      sign_p;

    assign cls_a  = fp_classify_sp(a_i);
    assign cls_b  = fp_classify_sp(b_i);
    assign sign_p = a_i[31] ^ b_i[31];

    // NOTE: every output gets a default before the if-chain so no path leaves
    // a signal unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        special_o = 1'b1;
        result_o  = '0;
        if (cls_a == NAN || cls_b == NAN) begin
            result_o = FP_QNAN_SP;
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            result_o = FP_QNAN_SP;
        end else if (cls_a == INF || cls_b == INF) begin
            result_o = {sign_p, FP_EXP_MAX_SP, 23'b0};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            result_o = {sign_p, 31'b0};
        end else begin
            special_o = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_mul_operand_queue_sp.sv
// -----------------------------------------------------------------------------
// fpu_mul_operand_queue_sp
// Operand-staging FIFO in front of fpu_multiplier_sp. Buffers binary32 operand
// pairs with valid/ready handshakes, classifies them on push and stores a
// precomputed product for NaN/Inf/zero cases so downstream can bypass the
// multiplier. Head entry is presented first-word fall-through.
//
// Build option: define FPU_DAZ_EN to flush subnormal operands to signed zero
// on push (stored flushed). Undefined: operands are stored unmodified.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous queue clear (beats push/pop)
//   in_valid/in_ready      producer handshake; in_a, in_b operands
//   out_valid/out_ready    consumer handshake; out_a, out_b head operands
//   out_special            head product decided without multiplication
//   out_special_result     that product (0 when out_special=0)
//   count                  occupancy
//   stall_cnt              saturating count of refused offers
// -----------------------------------------------------------------------------
module fpu_mul_operand_queue_sp
    import fpu_sp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int STALL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_a,
    output logic [31:0]              out_b,
    output logic                     out_special,
    output logic [31:0]              out_special_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    q_entry_t           mem_q [DEPTH];

    logic        push, pop;
    logic [31:0] a_enq, b_enq;
    logic        enq_special;
    logic [31:0] enq_result;

    // Handshake flags come from registered count only.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef FPU_DAZ_EN
    assign a_enq = fp_daz_sp(in_a);
    assign b_enq = fp_daz_sp(in_b);
`else
    assign a_enq = in_a;
    assign b_enq = in_b;
`endif

    // Classification sees the operands exactly as they will be stored.
    fpu_special_case_sp u_special (
        .a_i      (a_enq),
        .b_i      (b_enq),
        .special_o(enq_special),
        .result_o (enq_result)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // Refused offers are counted regardless of flush; saturate at all-ones.
        if (in_valid && !in_ready && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: storage is reset on purpose: the head is visible combinationally,
    // so the outputs must read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{a: a_enq, b: b_enq, special: enq_special, result: enq_result};
        end
    end

    assign out_a              = mem_q[rd_ptr_q].a;
    assign out_b              = mem_q[rd_ptr_q].b;
    assign out_special        = mem_q[rd_ptr_q].special;
    assign out_special_result = mem_q[rd_ptr_q].result;
    assign count              = count_q;
    assign stall_cnt          = stall_q;

endmodule

// File: tb/tb_fpu_mul_operand_queue_sp.sv
// -----------------------------------------------------------------------------
// tb_fpu_mul_operand_queue_sp
// Self-checking bench for fpu_mul_operand_queue_sp. A queue-based reference
// model computes expected entries from the IEEE special-case rules.
// -----------------------------------------------------------------------------
module tb_fpu_mul_operand_queue_sp;

    localparam int DEPTH   = 4;
    localparam int STALL_W = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [31:0]        in_a = '0;
    logic [31:0]        in_b = '0;
    logic               in_ready, out_valid, out_special;
    logic [31:0]        out_a, out_b, out_special_result;
    logic [CW-1:0]      count;
    logic [STALL_W-1:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] res;
    } exp_t;

    exp_t mq[$];
    int   stall_m = 0;

    fpu_mul_operand_queue_sp #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_a              (in_a),
        .in_b              (in_b),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_a             (out_a),
        .out_b             (out_b),
        .out_special       (out_special),
        .out_special_result(out_special_result),
        .count             (count),
        .stall_cnt         (stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_daz(input logic [31:0] x);
`ifdef FPU_DAZ_EN
        if (x[30:23] == 8'd0 && x[22:0] != 23'd0) return {x[31], 31'b0};
`endif
        return x;
    endfunction

    function automatic exp_t model_entry(input logic [31:0] a0, input logic [31:0] b0);
        exp_t        e;
        logic [31:0] a, b;
        bit          na, nb, ia, ib, za, zb, s;
        a  = model_daz(a0);
        b  = model_daz(b0);
        na = (a[30:23] == 8'd255) && (a[22:0] != 0);
        nb = (b[30:23] == 8'd255) && (b[22:0] != 0);
        ia = (a[30:0] == 31'h7F80_0000);
        ib = (b[30:0] == 31'h7F80_0000);
        za = (a[30:0] == 31'd0);
        zb = (b[30:0] == 31'd0);
        s  = a[31] ^ b[31];
        e.a = a; e.b = b; e.sp = 1'b1; e.res = 32'd0;
        if (na || nb)                      e.res = 32'h7FC0_0000;
        else if ((ia && zb) || (za && ib)) e.res = 32'h7FC0_0000;
        else if (ia || ib)                 e.res = {s, 8'hFF, 23'd0};
        else if (za || zb)                 e.res = {s, 31'd0};
        else                               e.sp  = 1'b0;
        return e;
    endfunction

    // Drive one clock cycle of inputs, advance the model across the edge and
    // settle 1 time unit after the edge.
    task automatic do_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic ordy, input logic fl);
        bit push_m, pop_m;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        push_m = v && (mq.size() != DEPTH);
        pop_m  = ordy && (mq.size() != 0);
        if (v && mq.size() == DEPTH && stall_m != (1 << STALL_W) - 1) stall_m++;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop_m)  void'(mq.pop_front());
            if (push_m) mq.push_back(model_entry(a, b));
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_cycle(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0);
        tests_run++;
        if (count !== 3'd2) begin tests_failed++; $display("FAIL reset_prefill count got=%0d exp=2", count); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_async count=%0d out_valid=%0b exp 0/0", count, out_valid);
        end
        mq.delete();
        stall_m = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_flags count=%0d out_valid=%0b in_ready=%0b stall=%0d exp 0/0/1/0",
                     count, out_valid, in_ready, stall_cnt);
        end
        tests_run++;
        if (out_a !== 32'd0 || out_b !== 32'd0 || out_special !== 1'b0 || out_special_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data a=%h b=%h sp=%0b res=%h exp all zero", out_a, out_b, out_special, out_special_result);
        end
    endtask

    task automatic test_normal();
        do_cycle(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_a !== 32'h4000_0000 || out_b !== 32'h4040_0000 ||
            out_special !== 1'b0 || out_special_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL normal_pair v=%0b a=%h b=%h sp=%0b res=%h exp 1/40000000/40400000/0/0",
                     out_valid, out_a, out_b, out_special, out_special_result);
        end
        do_cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL normal_pop count=%0d v=%0b exp 0/0", count, out_valid);
        end
        // pop attempt on an empty queue changes nothing
        do_cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL empty_pop count=%0d v=%0b rdy=%0b exp 0/0/1", count, out_valid, in_ready);
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta [4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0001};
        logic [31:0] tb_ [4] = '{32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
        logic [31:0] tr [4] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, ta[i], tb_[i], 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_special !== 1'b1 || out_special_result !== tr[i]) begin
                tests_failed++;
                $display("FAIL special_%0d v=%0b sp=%0b res=%h exp 1/1/%h", i, out_valid, out_special,
                         out_special_result, tr[i]);
            end
            do_cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_full();
        logic [31:0] vals [5];
        int          s0;
        s0 = stall_m;
        for (int i = 0; i < 5; i++) begin
            vals[i] = 32'h3F80_0000 + i;
            do_cycle(1'b1, vals[i], 32'h4000_0000, 1'b0, 1'b0);
        end
        tests_run++;
        if (count !== 3'd4 || in_ready !== 1'b0 || stall_cnt !== 16'(s0 + 1)) begin
            tests_failed++;
            $display("FAIL full_fill count=%0d rdy=%0b stall=%0d exp 4/0/%0d", count, in_ready, stall_cnt, s0 + 1);
        end
        // full with push and pop together: push refused, pop proceeds
        do_cycle(1'b1, 32'hDEAD_BEEF, 32'h4000_0000, 1'b1, 1'b0);
        tests_run++;
        if (count !== 3'd3 || stall_cnt !== 16'(s0 + 2) || out_a !== vals[1]) begin
            tests_failed++;
            $display("FAIL full_pushpop count=%0d stall=%0d head=%h exp 3/%0d/%h", count, stall_cnt, out_a,
                     s0 + 2, vals[1]);
        end
        for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_a !== vals[i]) begin
                tests_failed++; $display("FAIL full_order_%0d v=%0b head=%h exp 1/%h", i, out_valid, out_a, vals[i]);
            end
            do_cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        tests_run++;
        if (count !== 3'd0) begin tests_failed++; $display("FAIL full_drain count=%0d exp 0", count); end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 32'd100, 32'h3F80_0000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'd101, 32'h3F80_0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (count !== 3'd2 || out_a !== 32'(100 + i)) begin
                tests_failed++; $display("FAIL b2b_%0d count=%0d head=%h exp 2/%h", i, count, out_a, 32'(100 + i));
            end
            do_cycle(1'b1, 32'(102 + i), 32'h3F80_0000, 1'b1, 1'b0);
        end
        tests_run++;
        if (count !== 3'd2 || out_a !== 32'd108) begin
            tests_failed++; $display("FAIL b2b_end count=%0d head=%h exp 2/0000006c", count, out_a);
        end
        do_cycle(1'b1, 32'h1234_5678, 32'h3F80_0000, 1'b1, 1'b1);
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush count=%0d v=%0b rdy=%0b exp 0/0/1", count, out_valid, in_ready);
        end
    endtask

    task automatic test_daz();
        logic [31:0] ea, er;
        logic        es;
`ifdef FPU_DAZ_EN
        ea = 32'h8000_0000; es = 1'b1; er = 32'h8000_0000;
`else
        ea = 32'h8000_0001; es = 1'b0; er = 32'h0000_0000;
`endif
        do_cycle(1'b1, 32'h8000_0001, 32'h3F80_0000, 1'b0, 1'b0);
        tests_run++;
        if (out_a !== ea || out_special !== es || out_special_result !== er) begin
            tests_failed++;
            $display("FAIL daz a=%h sp=%0b res=%h exp %h/%0b/%h", out_a, out_special, out_special_result, ea, es, er);
        end
        do_cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] pool [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                   32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h8000_0001,
                                   32'h3F80_0000, 32'hC000_0000};
        logic [31:0] a, b;
        int          errs;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(1, 0) == 1) ? pool[$urandom_range(9, 0)] : $urandom;
            b = ($urandom_range(1, 0) == 1) ? pool[$urandom_range(9, 0)] : $urandom;
            do_cycle($urandom_range(3, 0) != 0, a, b, $urandom_range(2, 0) == 0,
                     $urandom_range(29, 0) == 0);
            errs = 0;
            tests_run++;
            if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) ||
                in_ready !== (mq.size() != DEPTH) || stall_cnt !== STALL_W'(stall_m)) errs++;
            if (mq.size() != 0) begin
                if (out_a !== mq[0].a || out_b !== mq[0].b || out_special !== mq[0].sp ||
                    out_special_result !== mq[0].res) errs++;
            end
            if (errs != 0) begin
                tests_failed++;
                $display("FAIL random_%0d count=%0d/%0d stall=%0d/%0d head a=%h b=%h sp=%0b res=%h", n,
                         count, mq.size(), stall_cnt, stall_m, out_a, out_b, out_special, out_special_result);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        test_reset();
        test_normal();
        test_specials();
        test_full();
        test_back_to_back();
        test_daz();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
